uart_byte_tx: RTL and testbench
===============================

# uart_byte_tx

UART transmitter with a small input FIFO, the transmit-side counterpart of the board's UART receive path. It accepts bytes over a valid/ready handshake and serializes them as 8N1 frames (one start bit, 8 data bits LSB first, one stop bit) on `uart_tx`. It runs on the 30 MHz PLL clock domain so that, for example, received bytes can be echoed back or status reported to the Bluetooth module.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 260: clock cycles per UART bit (30 MHz / 115200 ≈ 260); legal range 2..65535.
- `DEPTH`, default 4: FIFO depth in bytes; must be a power of two, ≥ 2.

Ports:
- `clk`  input  1  system clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `tx_data`  input  8  byte to send; sampled when `tx_valid && tx_ready`.
- `tx_valid`  input  1  producer has a byte on `tx_data`.
- `tx_ready`  output  1  FIFO can accept a byte; equals not-full, registered.
- `uart_tx`  output  1  serial line, idle high, registered.
- `busy`  output  1  high while a frame is in flight or the FIFO is non-empty.
- `fifo_count`  output  $clog2(DEPTH)+1  bytes currently queued; excludes the byte being shifted.

## Operation
- The FIFO is a circular buffer with write and read pointers and an occupancy counter.
- Write: on an edge where `tx_valid && tx_ready`, `tx_data` is stored and the count increments.
- `tx_ready` depends only on occupancy. A byte popped in the same cycle does not make room until the next cycle, so there is no full-FIFO pass-through.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `uart_tx`=1. If count>0: pop the head byte into the shift register, drive `uart_tx`=0, clear the baud counter, go to START.
  - START: hold for `CLKS_PER_BIT` cycles, then drive bit0, bit index=0, go to DATA.
  - DATA: each bit is held `CLKS_PER_BIT` cycles, then the next bit is driven. After bit7's period, drive 1 and go to STOP.
  - STOP: hold 1 for `CLKS_PER_BIT` cycles. Then, if count>0, pop and drive 0 directly (START, no idle gap); otherwise go to IDLE.
- The baud counter runs 0..CLKS_PER_BIT-1, and a bit period ends at terminal count. The counter width is $clog2(CLKS_PER_BIT).
- The bit index is 3 bits and wraps only by the state change.
- A simultaneous push and pop leaves the count unchanged; both pointers advance.
- `tx_data` changes while `tx_valid` is low have no effect. Data already in the FIFO or the shift register is never altered by the inputs.
- `busy` = (state≠IDLE) or (count≠0), registered-equivalent (derived from registers only).

## Timing
- Reset values: `uart_tx`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0, FSM=IDLE, pointers=0.
- A reset asserted mid-frame aborts the frame. `uart_tx` is high after the reset edge, and queued bytes are discarded.
- Latency: a byte accepted at edge E into an empty FIFO with the FSM idle is popped at edge E+1. `uart_tx` goes low after edge E+1.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles. Back-to-back frames are contiguous, with each start bit following the previous stop bit with zero extra cycles.
- `tx_ready` deasserts on the edge after the write that fills the FIFO. It reasserts on the edge after the pop that frees a slot.
- `busy` falls on the edge at which the final stop bit completes with an empty FIFO.

## Test plan
Run all scenarios with `CLKS_PER_BIT`=4 and `DEPTH`=4.
- Single byte 0xA5 → `uart_tx` low 1 cycle after acceptance, then 0,1,0,1,0,0,1,0,1,1 each held 4 cycles. `busy` is high for exactly 41 cycles from the acceptance edge.
- Push 0x00, 0xFF, 0x55 on consecutive cycles → three contiguous 40-cycle frames with no idle gap. `fifo_count` goes 1, then 2 after the first pop, and is 0 after the third pop.
- Fill test: hold `tx_valid` high with bytes 0x01..0x06 → the first byte pops, 4 are queued, and `tx_ready` drops. The 6th byte is accepted only after the second pop. Six frames go out in order.
- Push and pop in the same cycle while the FIFO holds 2 bytes → `fifo_count` stays at 2, and byte order is preserved.
- Assert `reset` for 1 cycle during DATA bit 3 of 0x3C with 2 bytes queued → `uart_tx`=1 and `fifo_count`=0 next cycle. The line stays high 50 cycles, and no partial frame resumes.
- Toggle `tx_data` with `tx_valid` low while idle → `uart_tx` stays high, and `busy` and `fifo_count` stay 0.

Source files
------------

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 UART transmitter fed by a small byte FIFO
// Bytes queue in a circular buffer; the FSM pops one per frame, back-to-back when more are waiting.
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 260,
  parameter int DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     uart_tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          r_state;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_tx_ready;
  logic [BW-1:0]   r_baud;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_uart_tx;

  logic            w_push;
  logic            w_pop;
  logic            w_baud_done;
  logic [CW-1:0]   w_count_next;

  assign w_push      = tx_valid & r_tx_ready;
  assign w_baud_done = (r_baud == BAUD_LAST);
  // A pop happens from IDLE, or straight out of a finished stop bit so frames stay contiguous.
  assign w_pop       = (r_count != '0) &&
                       ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_done));
  assign w_count_next = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  // Ready is computed from next occupancy, so a same-cycle pop never lets a full FIFO accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tx_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count    <= w_count_next;
      r_tx_ready <= (w_count_next != FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_uart_tx <= 1'b1;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_uart_tx <= 1'b1;
          if (w_pop) begin
            r_shift   <= r_mem[r_rd_ptr];
            r_uart_tx <= 1'b0;
            r_baud    <= '0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_baud_done) begin
            r_uart_tx <= r_shift[0];
            r_bit_idx <= '0;
            r_baud    <= '0;
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_uart_tx <= 1'b1;
              r_state   <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_uart_tx <= r_shift[1];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift   <= r_mem[r_rd_ptr];
              r_uart_tx <= 1'b0;
              r_state   <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_uart_tx <= 1'b1;
        end
      endcase
    end
  end

  assign tx_ready   = r_tx_ready;
  assign uart_tx    = r_uart_tx;
  assign fifo_count = r_count;
  assign busy       = (r_state != S_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb/tb_uart_byte_tx.sv - directed bench for uart_byte_tx with a waveform-queue reference model
// The model expands each popped byte into its 10*CPB line samples; a receiver decodes the DUT line.
module tb_uart_byte_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic          uart_tx;
  logic          busy;
  logic [CW-1:0] fifo_count;

  uart_byte_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, line as a queue of upcoming samples.
  logic [7:0] mq[$];
  logic       wave[$];
  logic       m_line = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_ready = 1'b1;
  logic       m_active;
  logic       m_push;
  logic [7:0] m_b;
  int         m_count = 0;
  int         m_bitpos;
  bit         m_started = 1'b0;
  int         resets_seen = 0;

  always @(posedge clk) begin
    m_started = 1'b1;
    if (reset) begin
      mq.delete();
      wave.delete();
      m_line = 1'b1;
      m_busy = 1'b0;
      resets_seen++;
    end else begin
      m_push = tx_valid && (mq.size() < DEPTH);
      if (wave.size() == 0 && mq.size() != 0) begin
        m_b = mq.pop_front();
        for (int i = 0; i < 10 * CPB; i++) begin
          m_bitpos = i / CPB;
          if (m_bitpos == 0)      wave.push_back(1'b0);
          else if (m_bitpos == 9) wave.push_back(1'b1);
          else                    wave.push_back(m_b[m_bitpos-1]);
        end
      end
      if (m_push) mq.push_back(tx_data);
      if (wave.size() != 0) begin
        m_line   = wave.pop_front();
        m_active = 1'b1;
      end else begin
        m_line   = 1'b1;
        m_active = 1'b0;
      end
      m_busy = m_active || (mq.size() != 0);
    end
    m_count = mq.size();
    m_ready = (mq.size() < DEPTH);
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("model_uart_tx", {31'd0, uart_tx}, {31'd0, m_line});
      check("model_busy", {31'd0, busy}, {31'd0, m_busy});
      check("model_tx_ready", {31'd0, tx_ready}, {31'd0, m_ready});
      check("model_fifo_count", {{(32-CW){1'b0}}, fifo_count}, m_count);
    end
  end

  // Line receiver: samples each bit mid-period and collects decoded bytes.
  int         rx_cnt = 0;
  int         rx_seen = 0;
  int         rx_k;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (rx_seen != resets_seen) begin
      rx_cnt  = 0;
      rx_seen = resets_seen;
    end
    if (m_started) begin
      if (rx_cnt == 0) begin
        if (uart_tx === 1'b0) rx_cnt = 1;
      end else begin
        rx_cnt++;
        if (rx_cnt >= CPB + CPB/2 + 1 && (rx_cnt - CPB/2 - 1) % CPB == 0) begin
          rx_k = (rx_cnt - CPB/2 - 1) / CPB - 1;
          if (rx_k < 8) rx_byte[rx_k] = uart_tx;
          else if (rx_k == 8) begin
            check("rx_stop_bit", {31'd0, uart_tx}, 1);
            rx_q.push_back(rx_byte);
          end
        end
        if (rx_cnt == 10 * CPB) rx_cnt = 0;
      end
    end
  end

  task automatic push_one(input logic [7:0] b, output int waited);
    int n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("push_wait_bound", {31'd0, (n < 300)}, 1);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    waited   = n;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait_bound", {31'd0, (n < 1000)}, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_rx(input int base, input logic [7:0] exp[$]);
    check("rx_frame_count", rx_q.size() - base, exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < rx_q.size()) check("rx_byte", {24'd0, rx_q[base+i]}, {24'd0, exp[i]});
    end
  endtask

  initial begin
    int         w;
    int         base;
    int         busy_n;
    logic [9:0] pat_a5;
    logic [7:0] exp_q[$];

    pat_a5 = 10'b1101001010;
    repeat (2) @(negedge clk);
    check("reset_uart_tx", {31'd0, uart_tx}, 1);
    check("reset_tx_ready", {31'd0, tx_ready}, 1);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_fifo_count", {{(32-CW){1'b0}}, fifo_count}, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Single byte 0xA5
    base = rx_q.size();
    push_one(8'hA5, w);
    check("a5_count_after_accept", {{(32-CW){1'b0}}, fifo_count}, 1);
    busy_n = 0;
    while (busy === 1'b1 && busy_n < 200) begin
      busy_n++;
      if (busy_n >= 2 && busy_n <= 41)
        check("a5_line_sample", {31'd0, uart_tx}, {31'd0, pat_a5[(busy_n-2)/CPB]});
      @(negedge clk);
    end
    check("a5_busy_cycles", busy_n, 41);
    wait_idle();
    exp_q = '{8'hA5};
    expect_rx(base, exp_q);

    // Three consecutive bytes
    base = rx_q.size();
    push_one(8'h00, w);
    check("burst_count_1", {{(32-CW){1'b0}}, fifo_count}, 1);
    push_one(8'hFF, w);
    check("burst_count_2", {{(32-CW){1'b0}}, fifo_count}, 1);
    push_one(8'h55, w);
    check("burst_count_3", {{(32-CW){1'b0}}, fifo_count}, 2);
    wait_idle();
    exp_q = '{8'h00, 8'hFF, 8'h55};
    expect_rx(base, exp_q);

    // Fill test
    base = rx_q.size();
    for (int i = 1; i <= 6; i++) begin
      push_one(8'(i), w);
      if (i == 5) begin
        check("fill_ready_low", {31'd0, tx_ready}, 0);
        check("fill_count_full", {{(32-CW){1'b0}}, fifo_count}, 4);
      end
      if (i == 6) check("fill_sixth_wait", w, 37);
    end
    wait_idle();
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    expect_rx(base, exp_q);

    // Simultaneous push and pop with two queued
    base = rx_q.size();
    push_one(8'h11, w);
    push_one(8'h22, w);
    push_one(8'h33, w);
    repeat (38) @(negedge clk);
    check("pp_count_before", {{(32-CW){1'b0}}, fifo_count}, 2);
    push_one(8'h44, w);
    check("pp_count_after", {{(32-CW){1'b0}}, fifo_count}, 2);
    wait_idle();
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    expect_rx(base, exp_q);

    // Reset during data bit 3 of 0x3C
    base = rx_q.size();
    push_one(8'h3C, w);
    push_one(8'h81, w);
    push_one(8'h7E, w);
    check("rst_count_queued", {{(32-CW){1'b0}}, fifo_count}, 2);
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_uart_tx", {31'd0, uart_tx}, 1);
    check("rst_fifo_count", {{(32-CW){1'b0}}, fifo_count}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("rst_line_high", {31'd0, uart_tx}, 1);
    end
    check("rst_no_frames", rx_q.size() - base, 0);

    // Data toggling with valid low
    for (int i = 0; i < 20; i++) begin
      tx_data = 8'($urandom);
      @(negedge clk);
      check("idle_toggle_line", {31'd0, uart_tx}, 1);
      check("idle_toggle_busy", {31'd0, busy}, 0);
      check("idle_toggle_count", {{(32-CW){1'b0}}, fifo_count}, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
